// File: rtl/beam_config_if.sv
// beam_config_if
// Bundles the byte-stream input, the read-request port and the configuration
// outputs of beam_config_loader.
//   slave  : used by beam_config_loader (consumes rx/rd inputs, drives status and config)
//   master : used by the UART/beamformer side (or a testbench)
// Signals: rx_data/rx_valid (byte stream), load_en (header enable), rd_req/rd_aline
// (readback request), busy/cfg_valid/err/rd_valid (status), channel_select,
// aline_count, pulse_shape, delays (committed configuration and readback data).
interface beam_config_if #(
  parameter int NUM_CH     = 8,
  parameter int NUM_ALINES = 16,
  parameter int DELAY_W    = 16
);
  logic [7:0]                  rx_data;
  logic                        rx_valid;
  logic                        load_en;
  logic                        rd_req;
  logic [$clog2(NUM_ALINES)-1:0] rd_aline;
  logic                        busy;
  logic                        cfg_valid;
  logic                        err;
  logic                        rd_valid;
  logic [NUM_CH-1:0]           channel_select;
  logic [7:0]                  aline_count;
  logic [31:0]                 pulse_shape;
  logic [NUM_CH*DELAY_W-1:0]   delays;

  modport slave (
    input  rx_data, rx_valid, load_en, rd_req, rd_aline,
    output busy, cfg_valid, err, rd_valid, channel_select, aline_count, pulse_shape, delays
  );

  modport master (
    output rx_data, rx_valid, load_en, rd_req, rd_aline,
    input  busy, cfg_valid, err, rd_valid, channel_select, aline_count, pulse_shape, delays
  );
endinterface

// File: rtl/beam_config_loader.sv
// beam_config_loader
// Receives a framed configuration stream (one byte per rx_valid strobe), stores
// channel mask, A-line count, pulse shape and a per-channel/per-A-line delay
// table, and commits the scalar configuration atomically at frame end. A read
// request returns one A-line's delays for all channels two cycles later.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - beam_config_if.slave (byte stream, read request, status, config outputs)
// Optional feature: define CFG_CHECKSUM_EN to require a trailing XOR checksum byte.
module beam_config_loader #(
  parameter int         NUM_CH      = 8,
  parameter int         NUM_ALINES  = 16,
  parameter int         DELAY_W     = 16,
  parameter logic [2:0] HANDSHAKE   = 3'b110,
  parameter int         TIMEOUT_CYC = 100000
) (
  input logic          clk,
  input logic          rst,
  beam_config_if.slave bus
);
  localparam int DB = (DELAY_W + 7) / 8;
  localparam int MB = (NUM_CH + 7) / 8;
  localparam int DW = 8 * DB;
  localparam int MW = 8 * MB;
  localparam int AW = $clog2(NUM_ALINES);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0]    MB_LAST = 2'(MB - 1);
  localparam logic [1:0]    DB_LAST = 2'(DB - 1);
  localparam logic [AW-1:0] A_LAST  = AW'(NUM_ALINES - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(NUM_CH - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MASK   = 3'd1;
  localparam logic [2:0] S_ALINE  = 3'd2;
  localparam logic [2:0] S_PULSE  = 3'd3;
  localparam logic [2:0] S_DELAY  = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;
  localparam logic [2:0] S_READ   = 3'd6;
`ifdef CFG_CHECKSUM_EN
  localparam logic [2:0] S_CKSUM  = 3'd7;
  localparam logic [2:0] S_AFTER_DELAY = S_CKSUM;
`else
  localparam logic [2:0] S_AFTER_DELAY = S_COMMIT;
`endif

  // 0 means "one A-line"; anything beyond the table depth saturates to the depth.
  function automatic logic [7:0] aline_clamp(input logic [7:0] b);
    logic [8:0] lim;
    lim = 9'(NUM_ALINES);
    if (b == 8'd0) return 8'd1;
    else if ({1'b0, b} > lim) return lim[7:0];
    else return b;
  endfunction

`ifdef CFG_CHECKSUM_EN
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  logic [2:0]              state_r;
  logic [1:0]              byte_idx_r;
  logic [AW-1:0]           a_idx_r;
  logic [CW-1:0]           ch_idx_r;
  logic [TW-1:0]           to_cnt_r;
  logic [MW-1:0]           mask_sh_r;
  logic [7:0]              aline_sh_r;
  logic [31:0]             pulse_sh_r;
  logic [DW-1:0]           word_sh_r;
  logic [AW-1:0]           rd_aline_r;
  logic                    busy_r;
  logic                    cfg_valid_r;
  logic                    err_r;
  logic                    rd_valid_r;
  logic [NUM_CH-1:0]       channel_select_r;
  logic [7:0]              aline_count_r;
  logic [31:0]             pulse_shape_r;
  logic [NUM_CH*DELAY_W-1:0] delays_r;
  logic [DELAY_W-1:0]      ram_r [NUM_CH][NUM_ALINES];
`ifdef CFG_CHECKSUM_EN
  logic [7:0]              csum_r;
`endif

  logic               rd_ok_s;
  logic               hdr_ok_s;
  logic               in_frame_s;
  logic               we_s;
  logic [DELAY_W-1:0] wr_word_s;

  // A read is only honoured from a coherent idle block; it beats a header in the same cycle.
  assign rd_ok_s  = (state_r == S_IDLE) && bus.rd_req && cfg_valid_r;
  assign hdr_ok_s = (state_r == S_IDLE) && bus.rx_valid && bus.load_en &&
                    (bus.rx_data[7:5] == HANDSHAKE) && !rd_ok_s;
`ifdef CFG_CHECKSUM_EN
  assign in_frame_s = (state_r == S_MASK) || (state_r == S_ALINE) || (state_r == S_PULSE) ||
                      (state_r == S_DELAY) || (state_r == S_CKSUM);
`else
  assign in_frame_s = (state_r == S_MASK) || (state_r == S_ALINE) || (state_r == S_PULSE) ||
                      (state_r == S_DELAY);
`endif
  assign we_s      = (state_r == S_DELAY) && bus.rx_valid && (byte_idx_r == DB_LAST);
  assign wr_word_s = DELAY_W'({word_sh_r, bus.rx_data});

  // Delay table: written on the final byte of each delay word, never reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      ram_r[ch_idx_r][a_idx_r] <= wr_word_s;
    end
  end

  // Frame/read FSM, shadow registers, timeout and committed outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= S_IDLE;
      byte_idx_r       <= 2'd0;
      a_idx_r          <= {AW{1'b0}};
      ch_idx_r         <= {CW{1'b0}};
      to_cnt_r         <= {TW{1'b0}};
      mask_sh_r        <= {MW{1'b0}};
      aline_sh_r       <= 8'd0;
      pulse_sh_r       <= 32'd0;
      word_sh_r        <= {DW{1'b0}};
      rd_aline_r       <= {AW{1'b0}};
      busy_r           <= 1'b0;
      cfg_valid_r      <= 1'b0;
      err_r            <= 1'b0;
      rd_valid_r       <= 1'b0;
      channel_select_r <= {NUM_CH{1'b0}};
      aline_count_r    <= 8'd0;
      pulse_shape_r    <= 32'd0;
      delays_r         <= {(NUM_CH*DELAY_W){1'b0}};
`ifdef CFG_CHECKSUM_EN
      csum_r           <= 8'd0;
`endif
    end else begin
      rd_valid_r <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      if (in_frame_s && bus.rx_valid) begin
        csum_r <= csum_next(csum_r, bus.rx_data);
      end
`endif
      // Inter-byte watchdog: abort after TIMEOUT_CYC silent cycles inside a frame.
      if (in_frame_s && !bus.rx_valid) begin
        if (to_cnt_r == TO_LAST) begin
          state_r     <= S_IDLE;
          err_r       <= 1'b1;
          busy_r      <= 1'b0;
          cfg_valid_r <= 1'b0;
        end else begin
          to_cnt_r <= to_cnt_r + TW'(1);
        end
      end else if (bus.rx_valid) begin
        to_cnt_r <= {TW{1'b0}};
      end
      case (state_r)
        S_IDLE: begin
          if (rd_ok_s) begin
            state_r    <= S_READ;
            rd_aline_r <= bus.rd_aline;
          end else if (hdr_ok_s) begin
            state_r     <= S_MASK;
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            cfg_valid_r <= 1'b0;
            byte_idx_r  <= 2'd0;
`ifdef CFG_CHECKSUM_EN
            csum_r      <= bus.rx_data;
`endif
          end
        end
        S_MASK: if (bus.rx_valid) begin
          mask_sh_r <= MW'({mask_sh_r, bus.rx_data});
          if (byte_idx_r == MB_LAST) begin
            byte_idx_r <= 2'd0;
            state_r    <= S_ALINE;
          end else begin
            byte_idx_r <= byte_idx_r + 2'd1;
          end
        end
        S_ALINE: if (bus.rx_valid) begin
          aline_sh_r <= aline_clamp(bus.rx_data);
          state_r    <= S_PULSE;
        end
        S_PULSE: if (bus.rx_valid) begin
          pulse_sh_r <= {pulse_sh_r[23:0], bus.rx_data};
          if (byte_idx_r == 2'd3) begin
            byte_idx_r <= 2'd0;
            a_idx_r    <= {AW{1'b0}};
            ch_idx_r   <= {CW{1'b0}};
            state_r    <= S_DELAY;
          end else begin
            byte_idx_r <= byte_idx_r + 2'd1;
          end
        end
        S_DELAY: if (bus.rx_valid) begin
          word_sh_r <= DW'({word_sh_r, bus.rx_data});
          if (byte_idx_r == DB_LAST) begin
            byte_idx_r <= 2'd0;
            if (a_idx_r == A_LAST) begin
              a_idx_r <= {AW{1'b0}};
              if (ch_idx_r == C_LAST) begin
                state_r <= S_AFTER_DELAY;
              end else begin
                ch_idx_r <= ch_idx_r + CW'(1);
              end
            end else begin
              a_idx_r <= a_idx_r + AW'(1);
            end
          end else begin
            byte_idx_r <= byte_idx_r + 2'd1;
          end
        end
`ifdef CFG_CHECKSUM_EN
        S_CKSUM: if (bus.rx_valid) begin
          if (bus.rx_data == csum_r) begin
            state_r <= S_COMMIT;
          end else begin
            state_r     <= S_IDLE;
            err_r       <= 1'b1;
            busy_r      <= 1'b0;
            cfg_valid_r <= 1'b0;
          end
        end
`endif
        S_COMMIT: begin
          channel_select_r <= mask_sh_r[NUM_CH-1:0];
          aline_count_r    <= aline_sh_r;
          pulse_shape_r    <= pulse_sh_r;
          cfg_valid_r      <= 1'b1;
          busy_r           <= 1'b0;
          state_r          <= S_IDLE;
        end
        S_READ: begin
          for (int k = 0; k < NUM_CH; k++) begin
            delays_r[k*DELAY_W +: DELAY_W] <= ram_r[k][rd_aline_r];
          end
          rd_valid_r <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_r;
  assign bus.cfg_valid      = cfg_valid_r;
  assign bus.err            = err_r;
  assign bus.rd_valid       = rd_valid_r;
  assign bus.channel_select = channel_select_r;
  assign bus.aline_count    = aline_count_r;
  assign bus.pulse_shape    = pulse_shape_r;
  assign bus.delays         = delays_r;
endmodule

// File: tb/tb_beam_config_loader.sv
// Self-checking bench for beam_config_loader: frames are driven byte by byte,
// expected readback vectors are queued at request time and compared when
// rd_valid pulses; scalar config and status are checked at fixed latencies.
module tb_beam_config_loader;
  localparam int NUM_CH     = 8;
  localparam int NUM_ALINES = 16;
  localparam int DELAY_W    = 16;
  localparam int TO         = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beam_config_if #(.NUM_CH(NUM_CH), .NUM_ALINES(NUM_ALINES), .DELAY_W(DELAY_W)) bus ();

  beam_config_loader #(
    .NUM_CH(NUM_CH), .NUM_ALINES(NUM_ALINES), .DELAY_W(DELAY_W),
    .HANDSHAKE(3'b110), .TIMEOUT_CYC(TO)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] rd_q[$];
  logic [7:0]   frame_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_delay(input int ch, input int a, input logic [15:0] key);
    return {8'(ch), 8'(a)} ^ key;
  endfunction

  function automatic logic [127:0] exp_lanes(input int a, input logic [15:0] key);
    logic [127:0] v;
    v = 128'd0;
    for (int k = 0; k < NUM_CH; k++) v[k*16 +: 16] = exp_delay(k, a, key);
    return v;
  endfunction

  // Scoreboard: every rd_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (rd_q.size() == 0) check("rd_unexpected", {127'd0, bus.rd_valid}, 128'd0);
      else check("rd_delays", bus.delays, rd_q.pop_front());
    end
  end

  task automatic build_frame(input logic [7:0] mask, input logic [7:0] aline,
                             input logic [31:0] pulse, input logic [15:0] key, input bit bad_cks);
    logic [15:0] d;
    logic [7:0]  x;
    frame_q.delete();
    frame_q.push_back(8'hC0);
    frame_q.push_back(mask);
    frame_q.push_back(aline);
    for (int i = 3; i >= 0; i--) frame_q.push_back(pulse[i*8 +: 8]);
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int a = 0; a < NUM_ALINES; a++) begin
        d = exp_delay(ch, a, key);
        frame_q.push_back(d[15:8]);
        frame_q.push_back(d[7:0]);
      end
    x = 8'd0;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    if (bad_cks) x = x ^ 8'h01;
`ifdef CFG_CHECKSUM_EN
    frame_q.push_back(x);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_byte(frame_q[i]);
      if (i == 0) begin
        check("hdr_busy", {127'd0, bus.busy}, 128'd1);
        check("hdr_cfg_clr", {127'd0, bus.cfg_valid}, 128'd0);
      end
    end
  endtask

  task automatic load_frame(input logic [7:0] mask, input logic [7:0] aline, input logic [7:0] exp_aline,
                            input logic [31:0] pulse, input logic [15:0] key);
    build_frame(mask, aline, pulse, key, 1'b0);
    send_range(0, frame_q.size() - 1);
    check("commit_early", {127'd0, bus.cfg_valid}, 128'd0);
    @(negedge clk);
    check("commit_cfg_valid", {127'd0, bus.cfg_valid}, 128'd1);
    check("commit_busy", {127'd0, bus.busy}, 128'd0);
    check("commit_err", {127'd0, bus.err}, 128'd0);
    check("commit_mask", {120'd0, bus.channel_select}, {120'd0, mask});
    check("commit_aline", {120'd0, bus.aline_count}, {120'd0, exp_aline});
    check("commit_pulse", {96'd0, bus.pulse_shape}, {96'd0, pulse});
  endtask

  task automatic do_read(input int a, input logic [15:0] key, input bit honoured);
    bus.rd_req   = 1'b1;
    bus.rd_aline = 4'(a);
    if (honoured) rd_q.push_back(exp_lanes(a, key));
    @(negedge clk);
    bus.rd_req = 1'b0;
    check("rd_early", {127'd0, bus.rd_valid}, 128'd0);
    @(negedge clk);
    check("rd_pulse", {127'd0, bus.rd_valid}, {127'd0, honoured});
    @(negedge clk);
    check("rd_single", {127'd0, bus.rd_valid}, 128'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {127'd0, bus.busy}, 128'd0);
    check({tag, "_cfg"}, {127'd0, bus.cfg_valid}, 128'd0);
    check({tag, "_err"}, {127'd0, bus.err}, 128'd0);
    check({tag, "_rdv"}, {127'd0, bus.rd_valid}, 128'd0);
    check({tag, "_mask"}, {120'd0, bus.channel_select}, 128'd0);
    check({tag, "_aline"}, {120'd0, bus.aline_count}, 128'd0);
    check({tag, "_pulse"}, {96'd0, bus.pulse_shape}, 128'd0);
    check({tag, "_delays"}, bus.delays, 128'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    bus.load_en  = 1'b1;
    bus.rd_req   = 1'b0;
    bus.rd_aline = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Read with no committed configuration is ignored.
    do_read(2, 16'h0000, 1'b0);

    // Header with load_en low, then a wrong handshake: both discarded.
    bus.load_en = 1'b0;
    send_byte(8'hC0);
    check("ign_load_en", {127'd0, bus.busy}, 128'd0);
    bus.load_en = 1'b1;
    send_byte(8'h40);
    check("ign_handshake", {127'd0, bus.busy}, 128'd0);

    load_frame(8'hA5, 8'd16, 8'd16, 32'hDEADBEEF, 16'h0000);
    do_read(5, 16'h0000, 1'b1);

    // Start another frame, try a read while busy, then stall after 10 bytes.
    build_frame(8'h3C, 8'd4, 32'h01020304, 16'h1111, 1'b0);
    send_range(0, 2);
    do_read(1, 16'h0000, 1'b0);
    send_range(3, 9);
    repeat (TO - 1) @(negedge clk);
    check("to_err_early", {127'd0, bus.err}, 128'd0);
    check("to_busy_early", {127'd0, bus.busy}, 128'd1);
    @(negedge clk);
    check("to_err", {127'd0, bus.err}, 128'd1);
    check("to_busy", {127'd0, bus.busy}, 128'd0);
    check("to_cfg", {127'd0, bus.cfg_valid}, 128'd0);
    check("to_mask_kept", {120'd0, bus.channel_select}, {120'd0, 8'hA5});

    // A new header clears the sticky error; reset mid-frame wipes everything.
    send_range(0, 0);
    check("hdr_clears_err", {127'd0, bus.err}, 128'd0);
    send_range(1, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");

    // A-line count 0 stored as 1; readback of the last A-line.
    load_frame(8'h5A, 8'd0, 8'd1, 32'h12345678, 16'h5A5A);
    do_read(15, 16'h5A5A, 1'b1);

    // Read and header in the same cycle: read wins, header dropped.
    bus.rx_data  = 8'hC0;
    bus.rx_valid = 1'b1;
    bus.rd_req   = 1'b1;
    bus.rd_aline = 4'd3;
    rd_q.push_back(exp_lanes(3, 16'h5A5A));
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rd_req   = 1'b0;
    check("coll_busy", {127'd0, bus.busy}, 128'd0);
    @(negedge clk);
    check("coll_rdv", {127'd0, bus.rd_valid}, 128'd1);
    @(negedge clk);
    check("coll_busy2", {127'd0, bus.busy}, 128'd0);

`ifdef CFG_CHECKSUM_EN
    // Corrupted checksum: error, configuration unchanged.
    build_frame(8'hFF, 8'd8, 32'hCAFEF00D, 16'h2222, 1'b1);
    send_range(0, frame_q.size() - 1);
    check("cks_err", {127'd0, bus.err}, 128'd1);
    check("cks_busy", {127'd0, bus.busy}, 128'd0);
    check("cks_cfg", {127'd0, bus.cfg_valid}, 128'd0);
    check("cks_mask_kept", {120'd0, bus.channel_select}, {120'd0, 8'h5A});
    check("cks_pulse_kept", {96'd0, bus.pulse_shape}, {96'd0, 32'h12345678});
`endif

    // Oversized A-line count saturates; readback of A-line 0.
    load_frame(8'h81, 8'd200, 8'd16, 32'h0BADF00D, 16'h0F0F);
    do_read(0, 16'h0F0F, 1'b1);

    repeat (2) @(negedge clk);
    check("sb_empty", 128'(rd_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
